// File: rtl/instruction_encoder.sv
// instruction_encoder: packs RV32I fields into 32-bit words and streams
// them to instruction memory at consecutive word addresses.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start, base_addr      restart the stream at base_addr (word aligned)
//   in_valid, in_ready    field bundle handshake
//   fmt, opcode, rd, rs1, rs2, funct3, funct7, imm
//                         instruction fields (fmt 0..5 = R,I,S,B,U,J)
//   mem_wr_en, mem_ready  word handshake toward memory
//   mem_addr, mem_wr_data byte address and encoded word
//   word_count            words accepted by memory since start (saturating)
//   enc_err               sticky range / illegal-format flag
module instruction_encoder #(
    parameter int ILEN    = 32,
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 16,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         fmt,
    input  logic [6:0]         opcode,
    input  logic [4:0]         rd,
    input  logic [4:0]         rs1,
    input  logic [4:0]         rs2,
    input  logic [2:0]         funct3,
    input  logic [6:0]         funct7,
    input  logic [XLEN-1:0]    imm,
    output logic               mem_wr_en,
    input  logic               mem_ready,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [ILEN-1:0]    mem_wr_data,
    output logic [COUNT_W-1:0] word_count,
    output logic               enc_err
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    logic            accept;
    logic            done;
    logic [ILEN-1:0] word;
    logic            bad;

    // Sign-extended views of the immediate; a legal immediate equals
    // the extension of its own low bits.
    logic [XLEN-1:0] sx12;
    logic [XLEN-1:0] sx13;
    logic [XLEN-1:0] sx21;

    assign sx12 = {{(XLEN-12){imm[11]}}, imm[11:0]};
    assign sx13 = {{(XLEN-13){imm[12]}}, imm[12:0]};
    assign sx21 = {{(XLEN-21){imm[20]}}, imm[20:0]};

    // reset_n gates in_ready so nothing is offered while held in reset.
    assign in_ready = reset_n && !start && (!mem_wr_en || mem_ready);
    assign accept   = in_valid && in_ready;
    assign done     = mem_wr_en && mem_ready;

    always_comb begin
        word = '0;
        bad  = 1'b0;
        case (fmt)
            FMT_R: begin
                word = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            FMT_I: begin
                word = {imm[11:0], rs1, funct3, rd, opcode};
                bad  = (imm != sx12);
            end
            FMT_S: begin
                word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                bad  = (imm != sx12);
            end
            FMT_B: begin
                word = {imm[12], imm[10:5], rs2, rs1, funct3,
                        imm[4:1], imm[11], opcode};
                bad  = imm[0] || (imm != sx13);
            end
            FMT_U: begin
                word = {imm[31:12], rd, opcode};
                bad  = (imm[11:0] != 12'd0);
            end
            FMT_J: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12],
                        rd, opcode};
                bad  = imm[0] || (imm != sx21);
            end
            default: begin
                // Illegal format: all-zero word is architecturally illegal.
                word = '0;
                bad  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_wr_en   <= 1'b0;
            mem_wr_data <= '0;
            mem_addr    <= '0;
            word_count  <= '0;
            enc_err     <= 1'b0;
        end else if (start) begin
            // Any pending word is dropped uncounted, even if taken now.
            mem_wr_en  <= 1'b0;
            mem_addr   <= {base_addr[ADDR_W-1:2], 2'b00};
            word_count <= '0;
            enc_err    <= 1'b0;
        end else begin
            if (done) begin
                mem_addr <= mem_addr + ADDR_W'(4);
                if (word_count != '1) begin
                    word_count <= word_count + COUNT_W'(1);
                end
            end
            if (accept) begin
                mem_wr_en   <= 1'b1;
                mem_wr_data <= word;
                if (bad) begin
                    enc_err <= 1'b1;
                end
            end else if (done) begin
                mem_wr_en <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// tb_instruction_encoder: directed plus randomized checks of the encoder
// against an arithmetic reference of the RV32I field layouts.
module tb_instruction_encoder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic        in_valid = 1'b0;
    logic [2:0]  fmt = '0;
    logic [6:0]  opcode = '0;
    logic [4:0]  rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [31:0] imm = '0;
    logic        mem_ready = 1'b0;

    logic        in_ready;
    logic        mem_wr_en;
    logic [15:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [15:0] word_count;
    logic        enc_err;

    logic        in_ready8;
    logic        mem_wr_en8;
    logic [7:0]  mem_addr8;
    logic [31:0] mem_wr_data8;
    logic [15:0] word_count8;
    logic        enc_err8;

    int n_checks = 0;
    int n_fails = 0;

    bit          m_wen;
    logic [15:0] m_addr;
    logic [31:0] m_data;
    int          m_count;
    bit          m_err;

    always #5 clk = ~clk;

    instruction_encoder dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .base_addr(base_addr), .in_valid(in_valid),
        .in_ready(in_ready), .fmt(fmt), .opcode(opcode),
        .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .funct7(funct7), .imm(imm), .mem_wr_en(mem_wr_en),
        .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .word_count(word_count),
        .enc_err(enc_err)
    );

    instruction_encoder #(.ADDR_W(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start),
        .base_addr(base_addr[7:0]), .in_valid(in_valid),
        .in_ready(in_ready8), .fmt(fmt), .opcode(opcode),
        .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .funct7(funct7), .imm(imm), .mem_wr_en(mem_wr_en8),
        .mem_ready(mem_ready), .mem_addr(mem_addr8),
        .mem_wr_data(mem_wr_data8), .word_count(word_count8),
        .enc_err(enc_err8)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference encoder: fields placed by shift/mask arithmetic,
    // legality by integer range tests on the byte offset.
    function automatic void ref_encode(output logic [31:0] w,
                                       output bit bad);
        int x;
        logic [31:0] f;
        x   = imm;
        bad = 0;
        f   = (32'(funct3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20);
        w   = 32'(opcode);
        case (fmt)
            3'd0: w |= f | (32'(rd) << 7) | (32'(funct7) << 25);
            3'd1: begin
                w |= (32'(rd) << 7) | (32'(funct3) << 12)
                   | (32'(rs1) << 15) | ((x & 'hFFF) << 20);
                bad = (x < -2048) || (x > 2047);
            end
            3'd2: begin
                w |= f | ((x & 31) << 7) | (((x >> 5) & 127) << 25);
                bad = (x < -2048) || (x > 2047);
            end
            3'd3: begin
                w |= f | (((x >> 11) & 1) << 7) | (((x >> 1) & 15) << 8)
                   | (((x >> 5) & 63) << 25) | (((x >> 12) & 1) << 31);
                bad = (x % 2 != 0) || (x < -4096) || (x > 4095);
            end
            3'd4: begin
                w |= (32'(rd) << 7) | (x & 32'hFFFF_F000);
                bad = (x & 'hFFF) != 0;
            end
            3'd5: begin
                w |= (32'(rd) << 7) | (((x >> 12) & 255) << 12)
                   | (((x >> 11) & 1) << 20) | (((x >> 1) & 1023) << 21)
                   | (((x >> 20) & 1) << 31);
                bad = (x % 2 != 0) || (x < -(1 << 20)) || (x >= (1 << 20));
            end
            default: begin
                w   = 32'h0;
                bad = 1;
            end
        endcase
    endfunction

    task automatic set_fields(input logic [2:0] f, input logic [6:0] op,
                              input logic [4:0] d, input logic [4:0] s1,
                              input logic [4:0] s2, input logic [2:0] f3,
                              input logic [6:0] f7, input int im);
        fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
        funct3 = f3; funct7 = f7; imm = im;
    endtask

    task automatic check_outputs();
        check("mem_wr_en", 32'(mem_wr_en), 32'(m_wen));
        check("word_count", 32'(word_count), 32'(m_count));
        check("enc_err", 32'(enc_err), 32'(m_err));
        check("mem_wr_en8", 32'(mem_wr_en8), 32'(m_wen));
        check("word_count8", 32'(word_count8), 32'(m_count));
        if (m_wen) begin
            check("mem_addr", 32'(mem_addr), 32'(m_addr));
            check("mem_wr_data", mem_wr_data, m_data);
            check("mem_addr8", 32'(mem_addr8), 32'(m_addr[7:0]));
        end
    endtask

    task automatic check_reset();
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_mem_wr_en", 32'(mem_wr_en), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_wr_data", mem_wr_data, 32'h0);
        check("rst_word_count", 32'(word_count), 32'h0);
        check("rst_enc_err", 32'(enc_err), 32'h0);
        check("rst_mem_addr8", 32'(mem_addr8), 32'h0);
    endtask

    task automatic model_reset();
        m_wen = 0; m_addr = '0; m_data = '0; m_count = 0; m_err = 0;
    endtask

    // One clock: drive at the falling edge, check, advance the model.
    task automatic step(input bit st, input bit iv, input bit mr);
        logic [31:0] w;
        bit bad, rdy, acc, done;
        start = st; in_valid = iv; mem_ready = mr;
        #1;
        check_outputs();
        rdy = !st && (!m_wen || mr);
        check("in_ready", 32'(in_ready), 32'(rdy));
        check("in_ready8", 32'(in_ready8), 32'(rdy));
        acc  = iv && rdy;
        done = m_wen && mr;
        ref_encode(w, bad);
        if (st) begin
            m_wen = 0; m_addr = base_addr & 16'hFFFC;
            m_count = 0; m_err = 0;
        end else begin
            if (done) begin
                m_addr = m_addr + 16'd4;
                if (m_count < 65535) m_count++;
            end
            if (acc) begin
                m_wen = 1; m_data = w; m_err = m_err | bad;
            end else if (done) begin
                m_wen = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic rand_fields();
        int r;
        fmt = 3'($urandom_range(0, 7));
        opcode = 7'($urandom); rd = 5'($urandom);
        rs1 = 5'($urandom); rs2 = 5'($urandom);
        funct3 = 3'($urandom); funct7 = 7'($urandom);
        r = $urandom_range(0, 3);
        case (r)
            0: imm = $urandom;
            1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            2: imm = 32'($urandom_range(0, 4095)) * 32'd512 - 32'h100000;
            default: imm = $urandom & 32'hFFFF_F000;
        endcase
    endtask

    initial begin
        model_reset();
        in_valid = 1; mem_ready = 1;
        #13;
        check_reset();
        @(negedge clk);
        reset_n = 1;

        // Single I word at 0x40.
        base_addr = 16'h40;
        step(1, 0, 0);
        set_fields(3'd1, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, -1);
        step(0, 1, 0);
        check("i_word", mem_wr_data, 32'hFFF1_0093);
        check("i_addr", 32'(mem_addr), 32'h40);
        check("i_err", 32'(enc_err), 32'h0);

        // Start with a word pending and mem_ready high: dropped.
        base_addr = 16'h100;
        step(1, 0, 1);
        check("drop_wen", 32'(mem_wr_en), 32'h0);
        check("drop_count", 32'(word_count), 32'h0);

        // Back-to-back stream.
        set_fields(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 0);
        step(0, 1, 1);
        check("r_word", mem_wr_data, 32'h0020_81B3);
        set_fields(3'd2, 7'b0100011, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 8);
        step(0, 1, 1);
        check("s_word", mem_wr_data, 32'h0051_2423);
        check("s_addr", 32'(mem_addr), 32'h104);
        set_fields(3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -4);
        step(0, 1, 1);
        check("b_word", mem_wr_data, 32'hFE00_0EE3);
        set_fields(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 2048);
        step(0, 1, 1);
        check("j_word", mem_wr_data, 32'h0010_00EF);
        check("j_addr", 32'(mem_addr), 32'h10C);
        step(0, 0, 1);
        check("stream_count", 32'(word_count), 32'd4);

        // Backpressure for five cycles.
        set_fields(3'd1, 7'b0010011, 5'd7, 5'd8, 5'd0, 3'd4, 7'd0, 100);
        step(0, 1, 1);
        repeat (5) step(0, 1, 0);
        check("stall_count", 32'(word_count), 32'd4);
        step(0, 0, 1);
        check("release_count", 32'(word_count), 32'd5);

        // Range and illegal format errors.
        step(1, 0, 1);
        set_fields(3'd1, 7'b0010011, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 2048);
        step(0, 1, 0);
        check("i2048_err", 32'(enc_err), 32'h1);
        check("i2048_hi", 32'(mem_wr_data[31:20]), 32'h800);
        step(1, 0, 1);
        set_fields(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0, 3);
        step(0, 1, 0);
        check("b3_err", 32'(enc_err), 32'h1);
        step(1, 0, 1);
        set_fields(3'd7, 7'h7F, 5'd31, 5'd31, 5'd31, 3'd7, 7'h7F, -1);
        step(0, 1, 1);
        check("fmt7_word", mem_wr_data, 32'h0);
        check("fmt7_err", 32'(enc_err), 32'h1);
        step(0, 0, 1);
        check("fmt7_count", 32'(word_count), 32'd1);
        step(1, 0, 0);
        check("clr_err", 32'(enc_err), 32'h0);
        check("clr_count", 32'(word_count), 32'h0);

        // Address wrap, 16-bit and 8-bit instances.
        base_addr = 16'hFFFD;
        step(1, 0, 0);
        set_fields(3'd4, 7'b0110111, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0,
                   32'h1234_5000);
        step(0, 1, 1);
        check("wrap_a0", 32'(mem_addr8), 32'hFC);
        step(0, 1, 1);
        check("wrap_a1", 32'(mem_addr8), 32'h00);
        check("wrap_a1_16", 32'(mem_addr), 32'h0000);
        step(0, 0, 1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            rand_fields();
            base_addr = 16'($urandom);
            step($urandom_range(0, 24) == 0, 1'($urandom),
                 $urandom_range(0, 3) != 0);
        end
        step(0, 0, 1);

        // Asynchronous reset in the middle of a write.
        set_fields(3'd0, 7'b0110011, 5'd9, 5'd10, 5'd11, 3'd0, 7'h20, 0);
        start = 0; in_valid = 1; mem_ready = 1;
        @(posedge clk);
        #2;
        reset_n = 0;
        #1;
        check_reset();
        model_reset();
        @(negedge clk);
        reset_n = 1;
        base_addr = 16'h0;
        step(1, 0, 0);
        step(0, 1, 1);
        check("post_rst_addr", 32'(mem_addr), 32'h0);
        check("post_rst_wen", 32'(mem_wr_en), 32'h1);
        step(0, 0, 1);
        #1;
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
